// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - FFT result capture buffer, drains 16 bins in natural frequency order
module output_buffer #(
    parameter int N      = 16,
    parameter int WIDTH  = 16,
    parameter int BITREV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [3:0]              wr_addr,
    input  logic signed [WIDTH-1:0] yr_in,
    input  logic signed [WIDTH-1:0] yi_in,
    input  logic                    frame_done,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [3:0]              out_idx,
    output logic signed [WIDTH-1:0] yr_out,
    output logic signed [WIDTH-1:0] yi_out,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_DRAIN = 1'b1;

    logic                    state;
    logic signed [WIDTH-1:0] yr_mem [N];
    logic signed [WIDTH-1:0] yi_mem [N];

    logic                    start;
    logic                    xfer;
    logic [3:0]              next_k;
    logic [3:0]              rd_addr;
    logic signed [WIDTH-1:0] rd_yr;
    logic signed [WIDTH-1:0] rd_yi;

    // Frequency bin k lives at bitrev4(k) when the core writes in scrambled order.
    function automatic logic [3:0] map_addr(input logic [3:0] k);
        return (BITREV != 0) ? {k[0], k[1], k[2], k[3]} : k;
    endfunction

    assign busy  = (state == S_DRAIN);
    assign start = (state == S_IDLE) && frame_done;
    assign xfer  = (state == S_DRAIN) && out_valid && out_ready;

    // Fetch the next bin to present; bypass a write landing in the same cycle as frame_done.
    always_comb begin
        next_k  = start ? 4'd0 : out_idx + 4'd1;
        rd_addr = map_addr(next_k);
        rd_yr   = yr_mem[rd_addr];
        rd_yi   = yi_mem[rd_addr];
        if (start && wr_en && (wr_addr == rd_addr)) begin
            rd_yr = yr_in;
            rd_yi = yi_in;
        end
    end

    // Result storage: writes land only while idle; drain-time writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                yr_mem[i] <= '0;
                yi_mem[i] <= '0;
            end
        end else if ((state == S_IDLE) && wr_en) begin
            yr_mem[wr_addr] <= yr_in;
            yi_mem[wr_addr] <= yi_in;
        end
    end

    // Drain sequencer: load bin 0 on frame_done, advance one bin per handshake, exit after bin 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= 4'd0;
            yr_out    <= '0;
            yi_out    <= '0;
        end else if (start) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_idx   <= 4'd0;
            yr_out    <= rd_yr;
            yi_out    <= rd_yi;
        end else if (xfer) begin
            if (out_idx == 4'd15) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_idx  <= next_k;
                yr_out   <= rd_yr;
                yi_out   <= rd_yi;
                out_last <= (next_k == 4'd15);
            end
        end
    end

    // Sticky flag for any write or frame_done that arrived while draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if ((state == S_DRAIN) && (wr_en || frame_done)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: doc/output_buffer.md
# output_buffer

Read-side counterpart to the FFT input buffer. Captures the 16 complex results written by the FFT core (addressed writes, optionally bit-reversed order). On a frame-complete pulse, streams them out one sample per handshake in natural frequency order. Sits between the last butterfly stage and the downstream consumer (display/UART/host bridge).

## Interface

**Parameters**
- `N` — default 16 — points per frame; only 16 is supported (4-bit addresses).
- `WIDTH` — default 16 — signed sample width, real and imaginary.
- `BITREV` — default 1 — 1: output index k reads memory address bitrev4(k); 0: reads address k.

**Ports**
- `clk` — in — 1 — sole clock; all state updates on rising edge.
- `rst` — in — 1 — asynchronous, active-low reset.
- `wr_en` — in — 1 — write strobe from FFT core.
- `wr_addr` — in — 4 — write address.
- `yr_in` — in — WIDTH — signed real result.
- `yi_in` — in — WIDTH — signed imaginary result.
- `frame_done` — in — 1 — single-cycle pulse: all 16 results written.
- `out_ready` — in — 1 — consumer can accept a sample.
- `out_valid` — out — 1 — `out_idx`/`yr_out`/`yi_out`/`out_last` are valid.
- `out_idx` — out — 4 — frequency bin index k of current sample.
- `yr_out` — out — WIDTH — signed real of bin k.
- `yi_out` — out — WIDTH — signed imaginary of bin k.
- `out_last` — out — 1 — high with bin 15.
- `busy` — out — 1 — high while draining.
- `overrun` — out — 1 — sticky: a write or `frame_done` was dropped during drain.

## Operation

- **Storage:** two N×WIDTH register arrays (`yr_mem`, `yi_mem`), cleared to 0 on reset.
- **FSM states:**
  - IDLE: writes accepted. `frame_done` moves to DRAIN.
  - DRAIN: writes blocked. Returns to IDLE after the transfer of bin 15.
- **Writes (IDLE only):** `wr_en` stores `yr_in`/`yi_in` at `wr_addr`. A later write to the same address overwrites the earlier one. No "all addresses written" check; unwritten locations hold the previous frame's data or 0.
- **Same-cycle write and `frame_done` in IDLE:** the write is committed, and the output register for bin 0 sees the new value (bypass when the write address equals the bin-0 map).
- **Entering DRAIN:**
  - Load output registers with bin 0: `out_idx`=0, data = mem[map(0)].
  - Set `out_valid`=1; `out_last`=0.
  - map(k) = bitrev4(k) if `BITREV`, else k. bitrev4 maps b3b2b1b0 → b0b1b2b3.
- **Transfer:** occurs when `out_valid` && `out_ready` at a rising edge.
  - If k<15: load bin k+1. `out_last` is set when loading bin 15.
  - If k=15: `out_valid`←0, `out_last`←0, state←IDLE.
- **Stall:** while `out_valid` && !`out_ready`, all outputs hold stable; no drop, no duplicate.
- **During DRAIN:**
  - Any `wr_en` is ignored (memory unchanged) and sets `overrun`.
  - `frame_done` is ignored and sets `overrun`.
  - This includes the cycle of the final transfer.
- **`overrun`:** cleared only by reset.
- **`busy`:** equals (state==DRAIN).
- **Arithmetic:** none; data is passed bit-exact. Index counter is 4-bit and never wraps mid-frame because DRAIN exits at 15.

## Timing

- **Reset (`rst`=0, asynchronous):** state=IDLE; `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0, `out_idx`=0, `yr_out`=`yi_out`=0; all memory=0. Takes effect immediately, including mid-drain; the frame is abandoned.
- **Write latency:** data written at edge t is readable by a `frame_done` at edge t (bypass) or later.
- **`frame_done` latency:** sampled at edge t → `out_valid`=1 and bin 0 presented after edge t (1 cycle).
- **Throughput:** with `out_ready` held high, bins 0..15 occupy 16 consecutive cycles. `out_valid` falls after the edge that transfers bin 15.
- **Back-to-back frames:** the earliest next `frame_done` is accepted at the first edge after returning to IDLE. Frame period is ≥17 cycles excluding writes.
- **`out_ready`:** may change any cycle; it has no combinational path to any output.

## Test plan

1. **Reset:** assert `rst`=0 mid-cycle → all outputs 0 immediately. Release, then hold `out_ready`=1 with no `frame_done` for 10 cycles → `out_valid` stays 0.
2. **Natural order (`BITREV`=0):** write addr i with yr=i, yi=−i for i=0..15, then pulse `frame_done`, `out_ready`=1 → 16 consecutive beats `out_idx`=k, yr=k, yi=−k. `out_last` only at k=15; `busy` falls after the last beat.
3. **Unscramble (`BITREV`=1):** write addr i with yr=i → yr_out sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with `out_idx` 0..15.
4. **Backpressure:** `out_ready` pattern 1,0,0,1,0,1… across the frame → exactly 16 transfers, and values are held constant across every stall cycle.
5. **Overrun:** during drain at k=5, pulse `wr_en` (addr 3, yr=0x7FFF) and `frame_done` → `overrun`=1, stream continues unchanged, and the next frame drain shows the old addr-3 value.
6. **Reset mid-drain:** assert `rst` at k=7 → `out_valid`=0 and memory cleared. A new frame of constants (yr=0x1234) drains correctly from bin 0.
